td_std_detect: RTL and testbench
================================

TD_STD_DETECT -- requirements
Module: td_std_detect

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- LINE_W, 10, line-counter width.
- NTSC_MIN, 258, lowest NTSC lines/field.
- NTSC_MAX, 268, highest NTSC lines/field.
- PAL_MIN, 308, lowest PAL lines/field.
- PAL_MAX, 318, highest PAL lines/field.
- LOCK_FIELDS, 4, consecutive matching fields needed to lock.
- MISS_FIELDS, 2, consecutive mismatching fields needed to unlock.
- HS_TIMEOUT, 4096, iCLK cycles without an HS edge before loss.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- iCLK in 1: the single clock.
- iRST in 1: asynchronous, active-high reset.
- iTD_HS in 1: raw decoder HS, asynchronous to iCLK.
- iTD_VS in 1: raw decoder VS, asynchronous to iCLK.
- oTD_Stable out 1: standard locked.
- oNTSC out 1: locked to NTSC.
- oPAL out 1: locked to PAL.
- oLine_Cnt out LINE_W: line count of the last completed field.
- oLost out 1: HS loss flag (only with TD_DETECT_TIMEOUT_EN).

Function
REQ-003 iTD_HS and iTD_VS SHALL each pass a 2-flop synchroniser followed by a rising-edge detector; only synchronised rising edges are used.
REQ-004 On each HS edge the line counter SHALL increment, saturating at 2^LINE_W-1 (no wrap).
REQ-005 On a VS edge the SHALL sequence is: latch the field count into oLine_Cnt, classify it, then restart the counter at 0.
REQ-006 Classification SHALL be NTSC if NTSC_MIN<=count<=NTSC_MAX, PAL if PAL_MIN<=count<=PAL_MAX, NONE otherwise; both bounds are inclusive and NTSC takes priority if the windows overlap.
REQ-007 When HS and VS edges occur in the same cycle, the field SHALL close with the pre-edge count and the new counter SHALL start at 1.
REQ-008 The FSM SHALL have states SEARCH, LOCKING and LOCKED, with a candidate register CAND and a 4-bit hit/miss counter:
- SEARCH: a field classed NTSC/PAL sets CAND and hit=1, then goes to LOCKING (or straight to LOCKED if LOCK_FIELDS==1); a NONE field stays in SEARCH.
- LOCKING: a field equal to CAND increments hit, and hit reaching LOCK_FIELDS goes to LOCKED; a different NTSC/PAL field reloads CAND with hit=1; a NONE field goes to SEARCH.
- LOCKED: a field equal to CAND clears miss; any other field increments miss, and miss reaching MISS_FIELDS goes to SEARCH.
REQ-009 oNTSC SHALL equal (state==LOCKED && CAND==NTSC), oPAL SHALL equal (state==LOCKED && CAND==PAL), and oTD_Stable SHALL equal oNTSC|oPAL; all three are registered.
REQ-010 Latency: an FSM or output change caused by a raw VS rising edge SHALL become visible at the 3rd iCLK rising edge after the first iCLK edge at which iTD_VS is sampled high.
REQ-011 The first VS edge after reset or after loss SHALL only start counting and SHALL NOT be classified.

Reset
REQ-012 iRST high SHALL asynchronously force the following, whether mid-field or in any state: synchronisers 0, counter 0, oLine_Cnt 0, CAND NONE, state SEARCH, hit/miss 0, oTD_Stable/oNTSC/oPAL/oLost 0.

Configuration
REQ-013 With macro TD_DETECT_TIMEOUT_EN defined, a watchdog SHALL count iCLK cycles since the last HS edge, and on reaching HS_TIMEOUT it SHALL:
- set oLost=1;
- force SEARCH and clear CAND, the counter and the outputs;
- re-arm REQ-011.
oLost SHALL clear on the next HS edge.
REQ-014 Without TD_DETECT_TIMEOUT_EN, oLost SHALL be tied 0 and no watchdog logic SHALL exist.

Structure
REQ-015 Package td_detect_pkg SHALL hold the FSM state enum, the standard enum (NONE/NTSC/PAL) and the default window constants.
REQ-016 Sub-module td_sync_edge (2-flop sync plus rising-edge pulse) SHALL be instantiated once for HS and once for VS.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- 4 fields of 262 lines -> oNTSC=1 and oTD_Stable=1 after the 4th classified field; oLine_Cnt=262.
- 4 fields of 312 lines -> oPAL=1; then 2 fields of 262 lines -> oPAL=0 and state SEARCH; then 4 more NTSC fields -> oNTSC=1.
- While locked NTSC, one 290-line field then 262-line fields -> lock retained (miss resets to 0).
- Counts 257, 258, 268, 269 -> classified NONE, NTSC, NTSC, NONE; 1500 lines with LINE_W=10 -> oLine_Cnt=1023.
- HS and VS edges in the same cycle -> closed field count excludes that HS, and the next field count starts at 1.
- iRST pulse mid-field while locked -> all outputs 0 immediately; with TD_DETECT_TIMEOUT_EN, stopping HS for 4096 cycles -> oLost=1 and oTD_Stable=0.

Source files
------------

// File: rtl/td_detect_pkg.sv
// td_detect_pkg: shared FSM/standard enums, default line windows and the window classifier
package td_detect_pkg;

    typedef enum logic [1:0] {ST_SEARCH, ST_LOCKING, ST_LOCKED} state_t;
    typedef enum logic [1:0] {STD_NONE, STD_NTSC, STD_PAL} std_t;

    localparam int NTSC_MIN_DEF = 258;
    localparam int NTSC_MAX_DEF = 268;
    localparam int PAL_MIN_DEF  = 308;
    localparam int PAL_MAX_DEF  = 318;

    // Inclusive windows; NTSC is tested first so it wins when the windows overlap
    function automatic std_t classify(input int unsigned cnt, input int unsigned n_min,
                                      input int unsigned n_max, input int unsigned p_min,
                                      input int unsigned p_max);
        return (cnt >= n_min && cnt <= n_max) ? STD_NTSC :
               (cnt >= p_min && cnt <= p_max) ? STD_PAL : STD_NONE;
    endfunction

endpackage

// File: rtl/td_sync_edge.sv
// td_sync_edge: 2-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse
module td_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_pulse
);

    logic [2:0] r_sh;

    // Two metastability stages, third stage holds the previous synchronised level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sh <= '0;
        else       r_sh <= {r_sh[1:0], i_d};
    end

    assign o_pulse = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/td_std_detect.sv
// td_std_detect: counts HS lines per VS field and locks onto NTSC/PAL; optional HS-loss watchdog under TD_DETECT_TIMEOUT_EN
module td_std_detect
    import td_detect_pkg::*;
#(
    parameter int LINE_W      = 10,
    parameter int NTSC_MIN    = NTSC_MIN_DEF,
    parameter int NTSC_MAX    = NTSC_MAX_DEF,
    parameter int PAL_MIN     = PAL_MIN_DEF,
    parameter int PAL_MAX     = PAL_MAX_DEF,
    parameter int LOCK_FIELDS = 4,
    parameter int MISS_FIELDS = 2,
    parameter int HS_TIMEOUT  = 4096
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iTD_HS,
    input  logic              iTD_VS,
    output logic              oTD_Stable,
    output logic              oNTSC,
    output logic              oPAL,
    output logic [LINE_W-1:0] oLine_Cnt,
    output logic              oLost
);

    localparam logic [LINE_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]        LOCK_N  = 4'(LOCK_FIELDS);
    localparam logic [3:0]        MISS_N  = 4'(MISS_FIELDS);

    logic              w_hs, w_vs, w_fire, w_to;
    logic [LINE_W-1:0] r_cnt, r_line;
    logic              r_seen, r_ntsc, r_pal, r_stable;
    state_t            r_state, w_state_nxt;
    std_t              r_cand, w_cand_nxt, w_cls;
    logic [3:0]        r_hit, w_hit_nxt, r_miss, w_miss_nxt;

    td_sync_edge u_hs (.i_clk(iCLK), .i_rst(iRST), .i_d(iTD_HS), .o_pulse(w_hs));
    td_sync_edge u_vs (.i_clk(iCLK), .i_rst(iRST), .i_d(iTD_VS), .o_pulse(w_vs));

    // The first VS after reset or loss only opens a field, it never closes one
    assign w_fire = w_vs & r_seen;
    assign w_cls  = classify(32'(r_cnt), NTSC_MIN, NTSC_MAX, PAL_MIN, PAL_MAX);

`ifdef TD_DETECT_TIMEOUT_EN
    localparam int WD_W = $clog2(HS_TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_lost;

    // Cycles since the last HS edge; saturates so the loss event fires only once per outage
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_wd   <= '0;
            r_lost <= 1'b0;
        end else if (w_hs) begin
            r_wd   <= '0;
            r_lost <= 1'b0;
        end else begin
            if (r_wd != WD_W'(HS_TIMEOUT)) r_wd <= r_wd + 1'b1;
            if (w_to) r_lost <= 1'b1;
        end
    end

    assign w_to  = !w_hs && (r_wd == WD_W'(HS_TIMEOUT - 1));
    assign oLost = r_lost;
`else
    assign w_to  = 1'b0;
    assign oLost = 1'b0;
`endif

    // Line counter: saturating HS count; VS closes the field and an HS in the same cycle opens the next at 1
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt  <= '0;
            r_line <= '0;
            r_seen <= 1'b0;
        end else if (w_to) begin
            r_cnt  <= '0;
            r_line <= '0;
            r_seen <= 1'b0;
        end else if (w_vs) begin
            r_cnt  <= w_hs ? LINE_W'(1) : '0;
            r_seen <= 1'b1;
            if (r_seen) r_line <= r_cnt;
        end else if (w_hs && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Lock FSM state, candidate standard and hit/miss hysteresis counters
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_SEARCH;
            r_cand  <= STD_NONE;
            r_hit   <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_hit   <= w_hit_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    // Next state: only a closed field (or a watchdog loss) moves the FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_hit_nxt   = r_hit;
        w_miss_nxt  = r_miss;
        if (w_to) begin
            w_state_nxt = ST_SEARCH;
            w_cand_nxt  = STD_NONE;
            w_hit_nxt   = '0;
            w_miss_nxt  = '0;
        end else if (w_fire) begin
            case (r_state)
                ST_LOCKED: begin
                    if (w_cls == r_cand) begin
                        w_miss_nxt = '0;
                    end else if (r_miss + 4'd1 >= MISS_N) begin
                        w_state_nxt = ST_SEARCH;
                        w_cand_nxt  = STD_NONE;
                        w_hit_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else begin
                        w_miss_nxt = r_miss + 4'd1;
                    end
                end
                default: begin
                    if (w_cls == STD_NONE) begin
                        w_state_nxt = ST_SEARCH;
                        w_cand_nxt  = STD_NONE;
                        w_hit_nxt   = '0;
                    end else begin
                        w_hit_nxt   = (r_state == ST_LOCKING && w_cls == r_cand) ? r_hit + 4'd1 : 4'd1;
                        w_cand_nxt  = w_cls;
                        w_miss_nxt  = '0;
                        w_state_nxt = (w_hit_nxt >= LOCK_N) ? ST_LOCKED : ST_LOCKING;
                    end
                end
            endcase
        end
    end

    // Registered status flags follow the next state so they appear on the same edge as the FSM change
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_ntsc   <= 1'b0;
            r_pal    <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_ntsc   <= (w_state_nxt == ST_LOCKED) && (w_cand_nxt == STD_NTSC);
            r_pal    <= (w_state_nxt == ST_LOCKED) && (w_cand_nxt == STD_PAL);
            r_stable <= (w_state_nxt == ST_LOCKED) && (w_cand_nxt != STD_NONE);
        end
    end

    assign oNTSC      = r_ntsc;
    assign oPAL       = r_pal;
    assign oTD_Stable = r_stable;
    assign oLine_Cnt  = r_line;

endmodule

// File: tb/tb_td_std_detect.sv
// tb_td_std_detect: directed and randomized checks of td_std_detect against a field-level reference model
module tb_td_std_detect;
    import td_detect_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic       stable, ntsc, pal, lost;
    logic [9:0] line;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one update per raw field; state 0=search 1=locking 2=locked, cand 0=none 1=ntsc 2=pal
    int m_seen, m_state, m_cand, m_hit, m_miss, m_line;

    td_std_detect dut (
        .iCLK(clk), .iRST(rst), .iTD_HS(hs), .iTD_VS(vs),
        .oTD_Stable(stable), .oNTSC(ntsc), .oPAL(pal), .oLine_Cnt(line), .oLost(lost)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ntsc();
        return m_state == 2 && m_cand == 1;
    endfunction

    function automatic logic exp_pal();
        return m_state == 2 && m_cand == 2;
    endfunction

    function automatic state_t exp_state();
        return m_state == 2 ? ST_LOCKED : m_state == 1 ? ST_LOCKING : ST_SEARCH;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_state = 0; m_cand = 0; m_hit = 0; m_miss = 0; m_line = 0;
    endtask

    task automatic model_field(input int n);
        int c;
        if (m_seen == 0) begin
            m_seen = 1;
            return;
        end
        m_line = n > 1023 ? 1023 : n;
        c = (m_line >= 258 && m_line <= 268) ? 1 : (m_line >= 308 && m_line <= 318) ? 2 : 0;
        if (m_state == 2) begin
            if (c == m_cand) m_miss = 0;
            else if (++m_miss >= 2) begin m_state = 0; m_cand = 0; m_hit = 0; m_miss = 0; end
        end else if (c == 0) begin
            m_state = 0; m_cand = 0; m_hit = 0;
        end else begin
            m_hit  = (m_state == 1 && c == m_cand) ? m_hit + 1 : 1;
            m_cand = c;
            m_miss = 0;
            m_state = m_hit >= 4 ? 2 : 1;
        end
    endtask

    task automatic hs_line();
        @(negedge clk) hs = 1'b1;
        @(negedge clk) hs = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic vs_pulse();
        @(negedge clk) vs = 1'b1;
        @(negedge clk) vs = 1'b0;
    endtask

    task automatic send_field(input int n);
        repeat (n) hs_line();
        vs_pulse();
        model_field(n);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) begin rst = 1'b1; hs = 1'b0; vs = 1'b0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic prime();
        vs_pulse();
        model_field(0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk) rst = 1'b1;
        #1;
        n_tests++;
        if ({stable, ntsc, pal, lost} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {stable, ntsc, pal, lost});
        end
        n_tests++;
        if (line !== 10'd0) begin n_fail++; $display("FAIL reset_line: got %0d want 0", line); end
        n_tests++;
        if (dut.r_state !== ST_SEARCH) begin n_fail++; $display("FAIL reset_state: got %0d want SEARCH", dut.r_state); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_ntsc_lock();
        do_reset();
        prime();
        for (int f = 0; f < 3; f++) begin
            send_field(262);
            n_tests++;
            if (stable !== 1'b0 || ntsc !== 1'b0) begin
                n_fail++; $display("FAIL ntsc_prelock f%0d: stable=%b ntsc=%b want 0 0", f, stable, ntsc);
            end
        end
        repeat (262) hs_line();
        @(negedge clk) vs = 1'b1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        n_tests++;
        if (ntsc !== 1'b0) begin n_fail++; $display("FAIL ntsc_latency_edge2: got %b want 0", ntsc); end
        @(posedge clk) #1;
        n_tests++;
        if (ntsc !== 1'b1) begin n_fail++; $display("FAIL ntsc_latency_edge3: got %b want 1", ntsc); end
        @(negedge clk) vs = 1'b0;
        model_field(262);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({stable, ntsc, pal} !== {exp_ntsc() | exp_pal(), exp_ntsc(), exp_pal()} || !exp_ntsc()) begin
            n_fail++; $display("FAIL ntsc_lock: got s/n/p=%b%b%b want 110", stable, ntsc, pal);
        end
        n_tests++;
        if (line !== 10'(m_line)) begin n_fail++; $display("FAIL ntsc_line: got %0d want %0d", line, m_line); end
    endtask

    task automatic test_pal_switch();
        do_reset();
        prime();
        repeat (4) send_field(312);
        n_tests++;
        if (pal !== 1'b1 || ntsc !== 1'b0 || stable !== 1'b1) begin
            n_fail++; $display("FAIL pal_lock: got s/n/p=%b%b%b want 101", stable, ntsc, pal);
        end
        send_field(262);
        n_tests++;
        if (pal !== exp_pal()) begin n_fail++; $display("FAIL pal_one_miss: got %b want %b", pal, exp_pal()); end
        send_field(262);
        n_tests++;
        if (pal !== 1'b0 || stable !== 1'b0) begin
            n_fail++; $display("FAIL pal_unlock: got pal=%b stable=%b want 0 0", pal, stable);
        end
        n_tests++;
        if (dut.r_state !== exp_state() || exp_state() != ST_SEARCH) begin
            n_fail++; $display("FAIL pal_unlock_state: got %0d want SEARCH", dut.r_state);
        end
        repeat (4) send_field(262);
        n_tests++;
        if (ntsc !== 1'b1 || pal !== 1'b0) begin
            n_fail++; $display("FAIL pal_to_ntsc: got ntsc=%b pal=%b want 1 0", ntsc, pal);
        end
    endtask

    task automatic test_miss_recover();
        int seq [4] = '{290, 262, 290, 262};
        foreach (seq[i]) begin
            send_field(seq[i]);
            n_tests++;
            if (ntsc !== exp_ntsc() || !exp_ntsc()) begin
                n_fail++; $display("FAIL miss_recover f%0d: got ntsc=%b want 1", i, ntsc);
            end
        end
        n_tests++;
        if (dut.r_miss !== 4'(m_miss)) begin n_fail++; $display("FAIL miss_clear: got %0d want %0d", dut.r_miss, m_miss); end
    endtask

    task automatic test_boundaries();
        int seq [4] = '{257, 258, 268, 269};
        do_reset();
        prime();
        foreach (seq[i]) begin
            send_field(seq[i]);
            n_tests++;
            if (dut.r_state !== exp_state()) begin
                n_fail++; $display("FAIL bound_%0d_state: got %0d want %0d", seq[i], dut.r_state, exp_state());
            end
            n_tests++;
            if (line !== 10'(m_line)) begin n_fail++; $display("FAIL bound_%0d_line: got %0d want %0d", seq[i], line, m_line); end
        end
        send_field(1500);
        n_tests++;
        if (line !== 10'd1023) begin n_fail++; $display("FAIL saturate_line: got %0d want 1023", line); end
    endtask

    task automatic test_same_cycle();
        int n, m;
        do_reset();
        prime();
        n = $urandom_range(20, 40);
        m = $urandom_range(20, 40);
        repeat (n) hs_line();
        @(negedge clk) begin hs = 1'b1; vs = 1'b1; end
        @(negedge clk) begin hs = 1'b0; vs = 1'b0; end
        model_field(n);
        repeat (4) @(negedge clk);
        n_tests++;
        if (line !== 10'(n)) begin n_fail++; $display("FAIL same_cycle_close: got %0d want %0d", line, n); end
        send_field(m);
        n_tests++;
        if (line !== 10'(m + 1)) begin n_fail++; $display("FAIL same_cycle_next: got %0d want %0d", line, m + 1); end
    endtask

    task automatic test_random();
        int n;
        int std_pick;
        do_reset();
        prime();
        std_pick = 0;
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(150, 400);
                1:       std_pick = 1 - std_pick;
                default: ;
            endcase
            if (f == 0 || n < 150 || $urandom_range(0, 5) != 0)
                n = std_pick == 0 ? $urandom_range(256, 270) : $urandom_range(306, 320);
            send_field(n);
            n_tests++;
            if ({stable, ntsc, pal} !== {exp_ntsc() | exp_pal(), exp_ntsc(), exp_pal()}) begin
                n_fail++; $display("FAIL random f%0d n=%0d: got s/n/p=%b%b%b want %b%b%b", f, n, stable, ntsc, pal,
                                   exp_ntsc() | exp_pal(), exp_ntsc(), exp_pal());
            end
            n_tests++;
            if (line !== 10'(m_line)) begin n_fail++; $display("FAIL random_line f%0d: got %0d want %0d", f, line, m_line); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        prime();
        repeat (4) send_field(262);
        n_tests++;
        if (ntsc !== 1'b1) begin n_fail++; $display("FAIL mid_prelock: got %b want 1", ntsc); end
        repeat (100) hs_line();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({stable, ntsc, pal, lost} !== 4'b0 || line !== 10'd0) begin
            n_fail++; $display("FAIL mid_reset: got s/n/p/l=%b line=%0d want 0000 0", {stable, ntsc, pal, lost}, line);
        end
        @(negedge clk) rst = 1'b0;
        model_reset();
    endtask

`ifdef TD_DETECT_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        prime();
        repeat (4) send_field(262);
        repeat (4110) @(negedge clk);
        model_reset();
        n_tests++;
        if (lost !== 1'b1 || stable !== 1'b0) begin
            n_fail++; $display("FAIL timeout: got lost=%b stable=%b want 1 0", lost, stable);
        end
        hs_line();
        repeat (4) @(negedge clk);
        n_tests++;
        if (lost !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", lost); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_ntsc_lock();
        test_pal_switch();
        test_miss_recover();
        test_boundaries();
        test_same_cycle();
        test_random();
        test_reset_mid();
`ifdef TD_DETECT_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
